// File: rtl/core_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_arbiter
//  Purpose  : Round-robin burst dispatcher from one scheduler stream to N cores
//  Revision : 1.0  initial release
// ============================================================================
module core_dispatch_arbiter #(
  parameter int CORE_NUM  = 16,
  parameter int WORD_W    = 16,
  parameter int BURST_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CORE_NUM-1:0] core_req,
  input  logic [CORE_NUM-1:0] core_word_ack,
  input  logic                sched_valid,
  input  logic [WORD_W-1:0]   sched_word,
  output logic                sched_reading,
  output logic [CORE_NUM-1:0] core_grant,
  output logic [WORD_W-1:0]   core_word,
  output logic                word_valid,
  output logic                burst_done,
  output logic                busy
);

  localparam int PW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST    = CW'(BURST_LEN);
  localparam logic [PW-1:0] PTR_MAX = PW'(CORE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       winner_q;
  logic [CORE_NUM-1:0] grant_q;
  logic [WORD_W-1:0]   word_q;
  logic                valid_q;
  logic                done_q;
  logic [CW-1:0]       issued_q;
  logic [CW-1:0]       acked_q;

  logic                found_d;
  logic [PW-1:0]       winner_d;
  logic [CORE_NUM-1:0] grant_d;
  logic                ack_sel_d;
  logic                pop_d;

  // First requester at or after rr_ptr, wrapping modulo CORE_NUM.
  always_comb begin : winner_scan
    logic [PW:0] idx;
    found_d  = 1'b0;
    winner_d = '0;
    idx      = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(CORE_NUM)) begin
        idx = idx - (PW+1)'(CORE_NUM);
      end
      if (!found_d && core_req[idx[PW-1:0]]) begin
        found_d  = 1'b1;
        winner_d = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    grant_d   = '0;
    grant_d[winner_d] = 1'b1;
    ack_sel_d = core_word_ack[winner_q] & valid_q;
    // An ack in the same cycle frees the slot, giving one word per cycle.
    pop_d     = reset && (state_q == XFER) && sched_valid &&
                (!valid_q || ack_sel_d) && (issued_q < LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      grant_q  <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
      acked_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (found_d) begin
            winner_q <= winner_d;
            grant_q  <= grant_d;
            issued_q <= '0;
            acked_q  <= '0;
            state_q  <= XFER;
          end
        end
        XFER: begin
          if (pop_d) begin
            word_q   <= sched_word;
            valid_q  <= 1'b1;
            issued_q <= issued_q + CW'(1);
          end else if (ack_sel_d) begin
            valid_q  <= 1'b0;
          end
          if (ack_sel_d) begin
            acked_q <= acked_q + CW'(1);
            if ((acked_q + CW'(1)) == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          grant_q  <= '0;
          valid_q  <= 1'b0;
          rr_ptr_q <= (winner_q == PTR_MAX) ? '0 : winner_q + PW'(1);
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sched_reading = pop_d;
  assign core_grant    = grant_q;
  assign core_word     = word_q;
  assign word_valid    = valid_q;
  assign burst_done    = done_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_dispatch_arbiter
//  Purpose  : Directed vector and sequence bench for core_dispatch_arbiter
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_dispatch_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] core_req;
  logic [15:0] core_word_ack;
  logic        sched_valid;
  logic [15:0] sched_word;
  logic        sched_reading;
  logic [15:0] core_grant;
  logic [15:0] core_word;
  logic        word_valid;
  logic        burst_done;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  core_dispatch_arbiter #(
    .CORE_NUM (16),
    .WORD_W   (16),
    .BURST_LEN(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_word_ack(core_word_ack),
    .sched_valid  (sched_valid),
    .sched_word   (sched_word),
    .sched_reading(sched_reading),
    .core_grant   (core_grant),
    .core_word    (core_word),
    .word_valid   (word_valid),
    .burst_done   (burst_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] ack;
    logic        sv;
    logic [15:0] sw;
    logic [15:0] e_grant;
    logic        e_valid;
    logic        e_chkword;
    logic [15:0] e_word;
    logic        e_rd;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic [15:0] req, logic [15:0] ack, logic sv,
                              logic [15:0] sw, logic [15:0] g, logic v, logic cw,
                              logic [15:0] w, logic rd, logic dn, logic bz);
    vec_t r;
    r.rst_n = rst_n; r.req = req; r.ack = ack; r.sv = sv; r.sw = sw;
    r.e_grant = g; r.e_valid = v; r.e_chkword = cw; r.e_word = w;
    r.e_rd = rd; r.e_done = dn; r.e_busy = bz;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    core_req = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Drives one burst to core gi with incrementing words from base and scores it.
  task automatic run_burst(input logic [15:0] req, input int gi, input logic [15:0] base,
                           input bit bp, input int stop_after);
    int          pops = 0;
    int          acks = 0;
    int          c    = 0;
    bit          done = 0;
    logic        pv   = 1'b0;
    logic        pa   = 1'b0;
    logic [15:0] pw   = '0;
    core_req = req;
    while (!done && c < 300) begin
      @(negedge clk);
      sched_valid       = !(bp && c >= 8 && c < 11);
      sched_word        = base + 16'(pops);
      core_word_ack     = '0;
      core_word_ack[gi] = bp ? c[0] : 1'b1;
      #1;
      if (pv && !pa) begin
        check("hold word", 32'(core_word), 32'(pw));
        check("hold valid", 32'(word_valid), 32'd1);
      end
      if (burst_done) done = 1;
      if (sched_reading) pops++;
      if (word_valid && core_word_ack[gi] && core_grant[gi]) begin
        check($sformatf("word %0d", acks), 32'(core_word), 32'(base + 16'(acks)));
        acks++;
        if (stop_after != 0 && acks == stop_after) return;
      end
      pv = word_valid;
      pa = core_word_ack[gi];
      pw = core_word;
      c++;
    end
    check("burst finished", 32'(done), 32'd1);
    check("pop count", 32'(pops), 32'd16);
    check("ack count", 32'(acks), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_rr [4];
    int          n;

    reset         = 1'b0;
    core_req      = 16'hFFFF;
    core_word_ack = '0;
    sched_valid   = 1'b0;
    sched_word    = '0;

    // Reset held with all cores requesting, then one full burst to core 2.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0004, 16'hFFFF, 1, 16'h0100, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 16'hFFFF, 1, 16'h0100, 16'h0004, 0, 0, 0, 1, 0, 1));
    for (int j = 1; j < 16; j++)
      tbl.push_back(mk(1, 0, 16'hFFFF, 1, 16'h0100 + 16'(j), 16'h0004, 1, 1,
                       16'h0100 + 16'(j - 1), 1, 0, 1));
    tbl.push_back(mk(1, 0, 16'hFFFF, 1, 16'h0110, 16'h0004, 1, 1, 16'h010F, 0, 0, 1));
    tbl.push_back(mk(1, 0, 16'hFFFF, 1, 16'h0111, 16'h0004, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 16'hFFFF, 1, 16'h0112, 16'h0000, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset         = tbl[i].rst_n;
      core_req      = tbl[i].req;
      core_word_ack = tbl[i].ack;
      sched_valid   = tbl[i].sv;
      sched_word    = tbl[i].sw;
      #1;
      check($sformatf("vec%0d grant", i), 32'(core_grant), 32'(tbl[i].e_grant));
      check($sformatf("vec%0d valid", i), 32'(word_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d reading", i), 32'(sched_reading), 32'(tbl[i].e_rd));
      check($sformatf("vec%0d done", i), 32'(burst_done), 32'(tbl[i].e_done));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_chkword)
        check($sformatf("vec%0d word", i), 32'(core_word), 32'(tbl[i].e_word));
    end

    // Round robin across cores 0, 4, 15 with requests held, including wrap.
    do_reset();
    @(negedge clk);
    core_req      = 16'h8011;
    core_word_ack = 16'hFFFF;
    sched_valid   = 1'b1;
    #1;
    exp_rr = '{16'h0001, 16'h0010, 16'h8000, 16'h0001};
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (core_grant == 16'h0 && n < 50) begin @(negedge clk); #1; n++; end
      check($sformatf("rr grant %0d", g), 32'(core_grant), 32'(exp_rr[g]));
      n = 0;
      while (!burst_done && n < 50) begin @(negedge clk); #1; n++; end
      check($sformatf("rr done %0d", g), 32'(burst_done), 32'd1);
      @(negedge clk);
      #1;
      check($sformatf("rr gap %0d", g), 32'(core_grant), 32'd0);
    end

    // Backpressure: toggling ack and a scheduler stall mid-burst.
    do_reset();
    run_burst(16'h0002, 1, 16'h0200, 1'b1, 0);

    // Reset after five words to core 3; rr_ptr must return to 0.
    run_burst(16'h0008, 3, 16'h0300, 1'b0, 5);
    @(negedge clk);
    reset    = 1'b0;
    core_req = '0;
    @(negedge clk);
    reset    = 1'b1;
    core_req = 16'h000A;
    #1;
    check("post-reset grant", 32'(core_grant), 32'd0);
    check("post-reset valid", 32'(word_valid), 32'd0);
    check("post-reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("post-reset rr_ptr", 32'(core_grant), 32'h0002);
    do_reset();
    run_burst(16'h0008, 3, 16'h0300, 1'b0, 0);

    // Spurious acks from every core except the granted core 3.
    do_reset();
    @(negedge clk);
    core_req      = 16'h0008;
    core_word_ack = 16'hFFF7;
    sched_valid   = 1'b1;
    sched_word    = 16'h0400;
    #1;
    check("spur idle grant", 32'(core_grant), 32'd0);
    @(negedge clk);
    #1;
    check("spur grant", 32'(core_grant), 32'h0008);
    check("spur first pop", 32'(sched_reading), 32'd1);
    @(negedge clk);
    sched_word = 16'h0401;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("spur word %0d", k), 32'(core_word), 32'h0400);
      check($sformatf("spur valid %0d", k), 32'(word_valid), 32'd1);
      check($sformatf("spur stall %0d", k), 32'(sched_reading), 32'd0);
      @(negedge clk);
      #1;
    end
    core_word_ack = 16'hFFFF;
    #1;
    check("real ack pops", 32'(sched_reading), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
